// File: rtl/packet_width_downsizer_if.sv
// Avalon-ST stream pair for the packet width downsizer: a wide input stream and a narrow output stream.
// master: the environment view (drives the input beat and the sink ready, observes the output word).
// slave:  the downsizer view (consumes the input beat, drives the output word).
interface packet_width_downsizer_if #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 32
);
  localparam int EW = $clog2(IN_WIDTH / OUT_WIDTH);

  logic [IN_WIDTH-1:0]  asi_in0_data;
  logic                 asi_in0_valid;
  logic                 asi_in0_ready;
  logic                 asi_in0_startofpacket;
  logic                 asi_in0_endofpacket;
  logic [EW-1:0]        asi_in0_empty;

  logic [OUT_WIDTH-1:0] aso_out0_data;
  logic                 aso_out0_valid;
  logic                 aso_out0_ready;
  logic                 aso_out0_startofpacket;
  logic                 aso_out0_endofpacket;

  modport master (
    output asi_in0_data, asi_in0_valid, asi_in0_startofpacket, asi_in0_endofpacket, asi_in0_empty,
    input  asi_in0_ready,
    input  aso_out0_data, aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket,
    output aso_out0_ready
  );

  modport slave (
    input  asi_in0_data, asi_in0_valid, asi_in0_startofpacket, asi_in0_endofpacket, asi_in0_empty,
    output asi_in0_ready,
    output aso_out0_data, aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket,
    input  aso_out0_ready
  );
endinterface

// File: rtl/packet_width_downsizer.sv
// Purpose: serialises IN_WIDTH-bit Avalon-ST beats into IN_WIDTH/OUT_WIDTH words, with partial EOP beats via empty.
// Latency: word 0 is valid the cycle after its beat is accepted; one word per cycle while the sink is ready.
// Backpressure: input ready when idle or on the final word's transfer (combinational from sink ready, no bubble).
// Ports: clock_clk, reset_reset (async, active-high), st (slave view of both streams),
//        stat_dropped_beats (saturating count of beats dropped outside a packet).
module packet_width_downsizer #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 32,
  parameter int MSB_FIRST = 1
) (
  input  logic                    clock_clk,
  input  logic                    reset_reset,
  packet_width_downsizer_if.slave st,
  output logic [15:0]             stat_dropped_beats
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int EW    = $clog2(RATIO);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic [IN_WIDTH-1:0]  buf_q;
  logic [EW-1:0]        idx_q, lim_q;
  logic                 buf_sop_q, buf_eop_q, in_packet_q;
  logic [15:0]          drop_cnt_q;
  logic                 loaded, last_word, out_xfer, in_rdy, in_xfer, drop_beat, take_beat;
  logic [OUT_WIDTH-1:0] word;

  assign loaded    = (state_q == SEND);
  assign last_word = (idx_q == lim_q);
  assign out_xfer  = loaded && st.aso_out0_ready;
  // Ready on the final word's transfer lets the next beat load in the same cycle.
  assign in_rdy    = !reset_reset && (!loaded || (out_xfer && last_word));
  assign in_xfer   = st.asi_in0_valid && in_rdy;
  // A beat arriving outside a packet without sop is consumed and discarded.
  assign drop_beat = in_xfer && !st.asi_in0_startofpacket && !in_packet_q;
  assign take_beat = in_xfer && !drop_beat;

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // A newly taken beat wins over returning to idle after the final word.
  always_comb begin
    state_d = state_q;
    if (take_beat)                  state_d = SEND;
    else if (out_xfer && last_word) state_d = IDLE;
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx_q == EW'(i)) begin
        if (MSB_FIRST != 0) word = buf_q[IN_WIDTH-1-i*OUT_WIDTH -: OUT_WIDTH];
        else                word = buf_q[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      buf_q       <= '0;
      idx_q       <= '0;
      lim_q       <= '0;
      buf_sop_q   <= 1'b0;
      buf_eop_q   <= 1'b0;
      in_packet_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      if (take_beat) begin
        buf_q       <= st.asi_in0_data;
        idx_q       <= '0;
        buf_sop_q   <= st.asi_in0_startofpacket;
        buf_eop_q   <= st.asi_in0_endofpacket;
        lim_q       <= st.asi_in0_endofpacket ? (EW'(RATIO - 1) - st.asi_in0_empty) : EW'(RATIO - 1);
        // Taken beats carry sop or continue a packet, so eop alone decides membership.
        in_packet_q <= !st.asi_in0_endofpacket;
      end else if (out_xfer) begin
        idx_q <= last_word ? '0 : idx_q + 1'b1;
      end
      if (drop_beat && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign st.asi_in0_ready          = in_rdy;
  assign st.aso_out0_valid         = loaded;
  assign st.aso_out0_data          = word;
  assign st.aso_out0_startofpacket = loaded && buf_sop_q && (idx_q == '0);
  assign st.aso_out0_endofpacket   = loaded && buf_eop_q && last_word;
  assign stat_dropped_beats        = drop_cnt_q;
endmodule

// File: tb/tb_packet_width_downsizer.sv
module tb_packet_width_downsizer;
  logic         clock_clk = 1'b0;
  logic         reset_reset;
  logic [255:0] in_data;
  logic         in_valid, in_sop, in_eop, out_ready;
  logic [2:0]   in_empty;
  logic [15:0]  stat_a, stat_b;
  int           errors = 0;
  int           checks = 0;

  always #5 clock_clk = ~clock_clk;

  packet_width_downsizer_if #(.IN_WIDTH(256), .OUT_WIDTH(32)) st_a ();
  packet_width_downsizer_if #(.IN_WIDTH(256), .OUT_WIDTH(32)) st_b ();

  assign st_a.asi_in0_data = in_data;          assign st_b.asi_in0_data = in_data;
  assign st_a.asi_in0_valid = in_valid;        assign st_b.asi_in0_valid = in_valid;
  assign st_a.asi_in0_startofpacket = in_sop;  assign st_b.asi_in0_startofpacket = in_sop;
  assign st_a.asi_in0_endofpacket = in_eop;    assign st_b.asi_in0_endofpacket = in_eop;
  assign st_a.asi_in0_empty = in_empty;        assign st_b.asi_in0_empty = in_empty;
  assign st_a.aso_out0_ready = out_ready;      assign st_b.aso_out0_ready = out_ready;

  packet_width_downsizer #(.IN_WIDTH(256), .OUT_WIDTH(32), .MSB_FIRST(1)) dut_a (
    .clock_clk(clock_clk), .reset_reset(reset_reset), .st(st_a), .stat_dropped_beats(stat_a));
  packet_width_downsizer #(.IN_WIDTH(256), .OUT_WIDTH(32), .MSB_FIRST(0)) dut_b (
    .clock_clk(clock_clk), .reset_reset(reset_reset), .st(st_b), .stat_dropped_beats(stat_b));

  // Beat whose 32-bit word i (counted from the LSB end) holds base+i.
  function automatic logic [255:0] make_beat(input logic [31:0] base);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = base + 32'(i);
    return b;
  endfunction

  task automatic step();
    @(posedge clock_clk);
    @(negedge clock_clk);
  endtask

  task automatic clear_in();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = 3'd0;
  endtask

  task automatic test_reset();
    reset_reset = 1'b1; in_data = '0; clear_in(); out_ready = 1'b1;
    #2;
    checks++; if (st_a.aso_out0_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", st_a.aso_out0_valid); end
    checks++; if (st_a.aso_out0_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %0h want 0", st_a.aso_out0_data); end
    checks++; if ({st_a.aso_out0_startofpacket, st_a.aso_out0_endofpacket} !== 2'b00) begin errors++; $display("FAIL reset_sop_eop: got %0b%0b want 00", st_a.aso_out0_startofpacket, st_a.aso_out0_endofpacket); end
    checks++; if (st_a.asi_in0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", st_a.asi_in0_ready); end
    checks++; if (stat_a !== 16'd0) begin errors++; $display("FAIL reset_stat: got %0d want 0", stat_a); end
    @(negedge clock_clk); @(negedge clock_clk);
    reset_reset = 1'b0;
    #1;
    checks++; if (st_a.asi_in0_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %0b want 1", st_a.asi_in0_ready); end
  endtask

  task automatic test_single_beat();
    in_data = make_beat(32'h0); in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_empty = 3'd0; out_ready = 1'b1;
    step(); clear_in();
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (st_a.aso_out0_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %0b want 1", k, st_a.aso_out0_valid); end
      checks++; if (st_a.aso_out0_data !== 32'(7 - k)) begin errors++; $display("FAIL single_data[%0d]: got %0h want %0h", k, st_a.aso_out0_data, 7 - k); end
      checks++; if (st_a.aso_out0_startofpacket !== (k == 0)) begin errors++; $display("FAIL single_sop[%0d]: got %0b want %0b", k, st_a.aso_out0_startofpacket, k == 0); end
      checks++; if (st_a.aso_out0_endofpacket !== (k == 7)) begin errors++; $display("FAIL single_eop[%0d]: got %0b want %0b", k, st_a.aso_out0_endofpacket, k == 7); end
      checks++; if (st_a.asi_in0_ready !== (k == 7)) begin errors++; $display("FAIL single_ready[%0d]: got %0b want %0b", k, st_a.asi_in0_ready, k == 7); end
      step();
    end
    #1;
    checks++; if (st_a.aso_out0_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got %0b want 0", st_a.aso_out0_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    in_data = make_beat(32'h100); in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_empty = 3'd0;
    step();
    in_data = make_beat(32'h200); in_sop = 1'b0; in_eop = 1'b1; in_empty = 3'd3;
    for (int k = 0; k < 13; k++) begin
      #1;
      exp = (k < 8) ? (32'h107 - 32'(k)) : (32'h207 - 32'(k - 8));
      checks++; if (st_a.aso_out0_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %0b want 1", k, st_a.aso_out0_valid); end
      checks++; if (st_a.aso_out0_data !== exp) begin errors++; $display("FAIL b2b_data[%0d]: got %0h want %0h", k, st_a.aso_out0_data, exp); end
      checks++; if (st_a.aso_out0_startofpacket !== (k == 0)) begin errors++; $display("FAIL b2b_sop[%0d]: got %0b want %0b", k, st_a.aso_out0_startofpacket, k == 0); end
      checks++; if (st_a.aso_out0_endofpacket !== (k == 12)) begin errors++; $display("FAIL b2b_eop[%0d]: got %0b want %0b", k, st_a.aso_out0_endofpacket, k == 12); end
      checks++; if (st_a.asi_in0_ready !== (k == 7 || k == 12)) begin errors++; $display("FAIL b2b_ready[%0d]: got %0b want %0b", k, st_a.asi_in0_ready, k == 7 || k == 12); end
      step();
      if (k == 7) clear_in();
    end
    #1;
    checks++; if (st_a.aso_out0_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %0b want 0", st_a.aso_out0_valid); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic prev_sop = 1'b0, prev_eop = 1'b0;
    in_data = make_beat(32'h300); in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_empty = 3'd0; out_ready = 1'b1;
    step(); clear_in();
    while (n < 8 && cyc < 64) begin
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      #1;
      checks++; if (st_a.aso_out0_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b want 1", cyc, st_a.aso_out0_valid); end
      if (prev_stall) begin
        checks++; if ({st_a.aso_out0_data, st_a.aso_out0_startofpacket, st_a.aso_out0_endofpacket} !== {prev_data, prev_sop, prev_eop})
          begin errors++; $display("FAIL bp_hold[%0d]: got %0h/%0b/%0b want %0h/%0b/%0b", cyc, st_a.aso_out0_data, st_a.aso_out0_startofpacket, st_a.aso_out0_endofpacket, prev_data, prev_sop, prev_eop); end
      end
      if (out_ready) begin
        checks++; if (st_a.aso_out0_data !== (32'h307 - 32'(n))) begin errors++; $display("FAIL bp_data[%0d]: got %0h want %0h", n, st_a.aso_out0_data, 32'h307 - 32'(n)); end
        checks++; if ({st_a.aso_out0_startofpacket, st_a.aso_out0_endofpacket} !== {n == 0, n == 7}) begin errors++; $display("FAIL bp_flags[%0d]: got %0b%0b want %0b%0b", n, st_a.aso_out0_startofpacket, st_a.aso_out0_endofpacket, n == 0, n == 7); end
        n++;
      end
      prev_stall = !out_ready;
      prev_data = st_a.aso_out0_data; prev_sop = st_a.aso_out0_startofpacket; prev_eop = st_a.aso_out0_endofpacket;
      step(); cyc++;
    end
    checks++; if (n != 8) begin errors++; $display("FAIL bp_count: got %0d words want 8 within 64 cycles", n); end
    out_ready = 1'b1;
    #1;
    checks++; if (st_a.aso_out0_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got valid %0b want 0", st_a.aso_out0_valid); end
  endtask

  task automatic test_drop();
    in_data = make_beat(32'h600); in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0;
    #1;
    checks++; if (st_a.asi_in0_ready !== 1'b1) begin errors++; $display("FAIL drop_ready: got %0b want 1", st_a.asi_in0_ready); end
    step(); clear_in();
    #1;
    checks++; if (st_a.aso_out0_valid !== 1'b0) begin errors++; $display("FAIL drop_no_output: got %0b want 0", st_a.aso_out0_valid); end
    checks++; if (stat_a !== 16'd1) begin errors++; $display("FAIL drop_stat: got %0d want 1", stat_a); end
    in_valid = 1'b1;
    repeat (65534) step();
    in_valid = 1'b0;
    #1;
    checks++; if (stat_a !== 16'hFFFF) begin errors++; $display("FAIL drop_stat_max: got %0d want 65535", stat_a); end
    checks++; if (st_a.aso_out0_valid !== 1'b0) begin errors++; $display("FAIL drop_still_idle: got %0b want 0", st_a.aso_out0_valid); end
    in_valid = 1'b1;
    repeat (5) step();
    in_valid = 1'b0;
    #1;
    checks++; if (stat_a !== 16'hFFFF) begin errors++; $display("FAIL drop_stat_sat: got %0d want 65535", stat_a); end
  endtask

  task automatic test_lsb_first();
    in_data = make_beat(32'h0); in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_empty = 3'd0; out_ready = 1'b1;
    #1;
    checks++; if (st_b.asi_in0_ready !== 1'b1) begin errors++; $display("FAIL lsb_ready: got %0b want 1", st_b.asi_in0_ready); end
    step(); clear_in();
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (st_b.aso_out0_data !== 32'(k)) begin errors++; $display("FAIL lsb_data[%0d]: got %0h want %0h", k, st_b.aso_out0_data, k); end
      checks++; if ({st_b.aso_out0_valid, st_b.aso_out0_startofpacket, st_b.aso_out0_endofpacket} !== {1'b1, k == 0, k == 7})
        begin errors++; $display("FAIL lsb_flags[%0d]: got %0b%0b%0b want 1%0b%0b", k, st_b.aso_out0_valid, st_b.aso_out0_startofpacket, st_b.aso_out0_endofpacket, k == 0, k == 7); end
      step();
    end
    #1;
    checks++; if (st_b.aso_out0_valid !== 1'b0) begin errors++; $display("FAIL lsb_idle: got %0b want 0", st_b.aso_out0_valid); end
  endtask

  task automatic test_reset_mid();
    in_data = make_beat(32'h400); in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_empty = 3'd0; out_ready = 1'b1;
    step(); clear_in();
    repeat (3) step();
    #1;
    checks++; if (st_a.aso_out0_data !== 32'h404) begin errors++; $display("FAIL mid_word3: got %0h want 404", st_a.aso_out0_data); end
    reset_reset = 1'b1;
    #1;
    checks++; if ({st_a.aso_out0_valid, st_a.aso_out0_startofpacket, st_a.aso_out0_endofpacket} !== 3'b000) begin errors++; $display("FAIL mid_rst_flags: got %0b%0b%0b want 000", st_a.aso_out0_valid, st_a.aso_out0_startofpacket, st_a.aso_out0_endofpacket); end
    checks++; if (st_a.aso_out0_data !== 32'h0) begin errors++; $display("FAIL mid_rst_data: got %0h want 0", st_a.aso_out0_data); end
    checks++; if (st_a.asi_in0_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %0b want 0", st_a.asi_in0_ready); end
    checks++; if (stat_a !== 16'd0) begin errors++; $display("FAIL mid_rst_stat: got %0d want 0", stat_a); end
    @(posedge clock_clk); @(negedge clock_clk);
    reset_reset = 1'b0;
    #1;
    checks++; if ({st_a.asi_in0_ready, st_a.aso_out0_valid} !== 2'b10) begin errors++; $display("FAIL mid_release: got ready/valid %0b%0b want 10", st_a.asi_in0_ready, st_a.aso_out0_valid); end
    in_data = make_beat(32'h700); in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b1;
    step(); clear_in();
    #1;
    checks++; if (st_a.aso_out0_valid !== 1'b0) begin errors++; $display("FAIL mid_nosop_output: got %0b want 0", st_a.aso_out0_valid); end
    checks++; if ({stat_a, stat_b} !== {16'd1, 16'd1}) begin errors++; $display("FAIL mid_nosop_stat: got %0d/%0d want 1/1", stat_a, stat_b); end
    in_data = make_beat(32'h500); in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1;
    step(); clear_in();
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (st_a.aso_out0_data !== (32'h507 - 32'(k))) begin errors++; $display("FAIL mid_data[%0d]: got %0h want %0h", k, st_a.aso_out0_data, 32'h507 - 32'(k)); end
      checks++; if ({st_a.aso_out0_valid, st_a.aso_out0_startofpacket, st_a.aso_out0_endofpacket} !== {1'b1, k == 0, k == 7})
        begin errors++; $display("FAIL mid_flags[%0d]: got %0b%0b%0b want 1%0b%0b", k, st_a.aso_out0_valid, st_a.aso_out0_startofpacket, st_a.aso_out0_endofpacket, k == 0, k == 7); end
      step();
    end
    #1;
    checks++; if (st_a.aso_out0_valid !== 1'b0) begin errors++; $display("FAIL mid_idle: got %0b want 0", st_a.aso_out0_valid); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_backpressure();
    test_drop();
    test_lsb_first();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
